// File: rtl/health_hit_ctrl.sv
// Player health, post-hit invulnerability with blink strobe, game-over and score
// accumulation. Sits between the monster detect units and the render/HUD logic.
module health_hit_ctrl #(
    parameter int          MONSTER_NUM   = 2,
    parameter int          HEALTH_INIT   = 5,
    parameter int          INVULN_CYCLES = 300_000_000,
    parameter int          BLINK_CYCLES  = 10_000_000,
    parameter logic [31:0] SCORE_STEP    = 32'd10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   restart,
    input  logic [MONSTER_NUM-1:0] hit,
    input  logic [MONSTER_NUM-1:0] frozen,
    output logic [3:0]             health,
    output logic                   invuln,
    output logic                   blink,
    output logic                   hit_pulse,
    output logic [3:0]             hit_idx,
    output logic                   game_over,
    output logic [31:0]            score
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [3:0]             health_next;
    logic                   blink_next;
    logic                   hit_pulse_next;
    logic [3:0]             hit_idx_next;
    logic [31:0]            score_next;
    logic [31:0]            inv_cnt, inv_cnt_next;
    logic [31:0]            blink_cnt, blink_cnt_next;
    logic [MONSTER_NUM-1:0] frozen_prev;
    logic [MONSTER_NUM-1:0] new_frozen;
    logic [4:0]             new_count;
    logic [37:0]            score_sum;
    logic [31:0]            score_sat;

    function automatic logic [4:0] count_ones(input logic [MONSTER_NUM-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < MONSTER_NUM; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [MONSTER_NUM-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = MONSTER_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Only rising freeze edges score; wide sum so any overflow can be clamped.
    always_comb begin
        new_frozen = frozen & ~frozen_prev;
        new_count  = count_ones(new_frozen);
        score_sum  = {6'd0, score} + (38'(new_count) * {6'd0, SCORE_STEP});
        score_sat  = (|score_sum[37:32]) ? 32'hFFFF_FFFF : score_sum[31:0];
    end

    always_comb begin
        state_next     = state;
        health_next    = health;
        blink_next     = blink;
        hit_pulse_next = 1'b0;
        hit_idx_next   = hit_idx;
        score_next     = score;
        inv_cnt_next   = inv_cnt;
        blink_cnt_next = blink_cnt;

        if (restart) begin
            state_next     = ALIVE;
            health_next    = 4'(HEALTH_INIT);
            blink_next     = 1'b0;
            score_next     = 32'd0;
            inv_cnt_next   = 32'd0;
            blink_cnt_next = 32'd0;
        end else begin
            if (state != DEAD) begin
                score_next = score_sat;
            end
            case (state)
                ALIVE: begin
                    if (|hit) begin
                        hit_pulse_next = 1'b1;
                        hit_idx_next   = lowest_set(hit);
                        if (health <= 4'd1) begin
                            state_next  = DEAD;
                            health_next = 4'd0;
                        end else begin
                            state_next     = INVULN;
                            health_next    = health - 4'd1;
                            inv_cnt_next   = 32'(INVULN_CYCLES - 1);
                            blink_cnt_next = 32'(BLINK_CYCLES - 1);
                            blink_next     = 1'b1;
                        end
                    end
                end
                INVULN: begin
                    if (inv_cnt == 32'd0) begin
                        state_next = ALIVE;
                        blink_next = 1'b0;
                    end else begin
                        inv_cnt_next = inv_cnt - 32'd1;
                        if (blink_cnt == 32'd0) begin
                            blink_cnt_next = 32'(BLINK_CYCLES - 1);
                            blink_next     = ~blink;
                        end else begin
                            blink_cnt_next = blink_cnt - 32'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ALIVE;
            health      <= 4'(HEALTH_INIT);
            blink       <= 1'b0;
            hit_pulse   <= 1'b0;
            hit_idx     <= 4'd0;
            score       <= 32'd0;
            inv_cnt     <= 32'd0;
            blink_cnt   <= 32'd0;
            frozen_prev <= '0;
        end else begin
            state       <= state_next;
            health      <= health_next;
            blink       <= blink_next;
            hit_pulse   <= hit_pulse_next;
            hit_idx     <= hit_idx_next;
            score       <= score_next;
            inv_cnt     <= inv_cnt_next;
            blink_cnt   <= blink_cnt_next;
            frozen_prev <= frozen;
        end
    end

    assign invuln    = (state == INVULN);
    assign game_over = (state == DEAD);

endmodule
